// File: rtl/switch_pkg.sv
// Shared types and constants for the push-button conditioner: debounce FSM
// state encoding, per-channel output bundle and counter sizing.
package switch_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } deb_state_t;

    localparam int DEBOUNCE_LIMIT_DEF = 250000;  // 10 ms at 25 MHz

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic toggle;
    } sw_out_t;

    // Counter only has to reach DEBOUNCE_LIMIT-1; keep at least one bit.
    function automatic int cnt_width(input int limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/switch_debounce_channel.sv
// One switch channel: synchroniser, four-state debounce FSM with stability
// counter, and registered press/release pulses plus push-to-toggle state.
module switch_debounce_channel
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF,
    parameter int SYNC_STAGES    = 2
) (
    input  logic    i_Clk,
    input  logic    i_Reset,
    input  logic    i_Switch,
    output sw_out_t o_Out
);

    localparam int              CW       = cnt_width(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   sync;

    deb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    sw_out_t       out_q, out_d;

    assign sync  = sync_pipe[SYNC_STAGES-1];
    assign o_Out = out_q;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync_pipe <= '0;
            state_q   <= STABLE_LOW;
            cnt_q     <= '0;
            out_q     <= '0;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], i_Switch};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
        end
    end

    // Pulses default low so they can only last the single committing cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_d        = out_q;
        out_d.press  = 1'b0;
        out_d.rel    = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (sync) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = STABLE_HIGH;
                    cnt_d        = '0;
                    out_d.level  = 1'b1;
                    out_d.press  = 1'b1;
                    out_d.toggle = ~out_q.toggle;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!sync) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = STABLE_LOW;
                    cnt_d       = '0;
                    out_d.level = 1'b0;
                    out_d.rel   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/switch_conditioner.sv
// Multi-channel push-button front end: one independent debounce channel per
// raw switch pin, outputs regrouped into per-function vectors.
module switch_conditioner
    import switch_pkg::*;
#(
    parameter int NUM_SW         = 4,
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF,
    parameter int SYNC_STAGES    = 2
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [NUM_SW-1:0] i_Switch,
    output logic [NUM_SW-1:0] o_Switch,
    output logic [NUM_SW-1:0] o_Press,
    output logic [NUM_SW-1:0] o_Release,
    output logic [NUM_SW-1:0] o_Toggle
);

    sw_out_t ch_out [NUM_SW];

    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        switch_debounce_channel #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_ch (
            .i_Clk    (i_Clk),
            .i_Reset  (i_Reset),
            .i_Switch (i_Switch[i]),
            .o_Out    (ch_out[i])
        );

        assign o_Switch[i]  = ch_out[i].level;
        assign o_Press[i]   = ch_out[i].press;
        assign o_Release[i] = ch_out[i].rel;
        assign o_Toggle[i]  = ch_out[i].toggle;
    end

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with DEBOUNCE_LIMIT=8, SYNC_STAGES=2.
module tb_switch_conditioner;

    localparam int NSW = 4;
    localparam int LAT = 2 + 8 - 1;  // first sampling edge to commit edge

    logic           clk = 1'b0;
    logic           rst;
    logic [NSW-1:0] sw_in;
    logic [NSW-1:0] sw_o, press_o, rel_o, tog_o;

    int n_tests = 0;
    int n_fail  = 0;

    switch_conditioner #(
        .NUM_SW         (NSW),
        .DEBOUNCE_LIMIT (8),
        .SYNC_STAGES    (2)
    ) dut (
        .i_Clk     (clk),
        .i_Reset   (rst),
        .i_Switch  (sw_in),
        .o_Switch  (sw_o),
        .o_Press   (press_o),
        .o_Release (rel_o),
        .o_Toggle  (tog_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // After tick(), outputs reflect the edge just taken.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        sw_in = '0;
        do_reset();
        chk("reset_outputs", {sw_o, press_o, rel_o, tog_o}, 32'h0);

        // Idle: nothing may move.
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle", {sw_o, press_o, rel_o, tog_o}, 32'h0);
        end

        // Clean press on ch0; commit on edge LAT.
        sw_in = 4'b0001;
        repeat (LAT) tick();
        chk("press_early_sw", sw_o, 4'b0000);
        chk("press_early_pulse", press_o, 4'b0000);
        tick();
        chk("press_sw", sw_o, 4'b0001);
        chk("press_pulse", press_o, 4'b0001);
        chk("press_toggle", tog_o, 4'b0001);
        chk("press_no_rel", rel_o, 4'b0000);
        tick();
        chk("press_pulse_width", press_o, 4'b0000);
        repeat (5) tick();

        // Clean release on ch0.
        sw_in = 4'b0000;
        repeat (LAT) tick();
        chk("rel_early_sw", sw_o, 4'b0001);
        chk("rel_early_pulse", rel_o, 4'b0000);
        tick();
        chk("rel_sw", sw_o, 4'b0000);
        chk("rel_pulse", rel_o, 4'b0001);
        chk("rel_no_press", press_o, 4'b0000);
        chk("rel_toggle_kept", tog_o, 4'b0001);
        tick();
        chk("rel_pulse_width", rel_o, 4'b0000);

        // Bounce on ch1: 3 high, 3 low, repeated, then quiet.
        for (int i = 0; i < 60; i++) begin
            sw_in[1] = (i < 40) && ((i / 3) % 2 == 0);
            tick();
            chk("bounce_ch1", {sw_o[1], press_o[1], tog_o[1]}, 3'b000);
        end

        // 7-cycle glitch on ch1.
        sw_in[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 7) sw_in[1] = 1'b0;
            tick();
            chk("glitch7_ch1", {sw_o[1], press_o[1], tog_o[1]}, 3'b000);
        end

        // ch2: 7 high, 1 low (drop lands on the would-be commit edge), then steady.
        sw_in[2] = 1'b1;
        repeat (7) tick();
        sw_in[2] = 1'b0;
        tick();
        sw_in[2] = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            tick();
            chk("boundary_no_press", {sw_o[2], press_o[2]}, 2'b00);
        end
        tick();
        chk("boundary_press", press_o, 4'b0100);
        chk("boundary_toggle", tog_o, 4'b0101);
        tick();
        chk("boundary_pulse_width", press_o, 4'b0000);
        sw_in[2] = 1'b0;
        repeat (LAT + 3) tick();
        chk("boundary_released", sw_o, 4'b0000);

        // All channels together from a fresh reset.
        do_reset();
        chk("reset2_toggle", tog_o, 4'b0000);
        sw_in = 4'b1111;
        repeat (LAT) tick();
        chk("all_early", press_o, 4'b0000);
        tick();
        chk("all_press", press_o, 4'b1111);
        chk("all_toggle", tog_o, 4'b1111);
        chk("all_sw", sw_o, 4'b1111);
        tick();
        chk("all_pulse_width", press_o, 4'b0000);
        sw_in = 4'b0000;
        repeat (LAT) tick();
        tick();
        chk("all_release", rel_o, 4'b1111);
        chk("all_rel_toggle", tog_o, 4'b1111);
        repeat (3) tick();

        // Second press of ch3 only.
        sw_in = 4'b1000;
        repeat (LAT + 1) tick();
        chk("ch3_press", press_o, 4'b1000);
        chk("ch3_toggle", tog_o, 4'b0111);
        sw_in = 4'b0000;
        repeat (LAT + 1) tick();
        chk("ch3_release", rel_o, 4'b1000);
        chk("ch3_rel_toggle", tog_o, 4'b0111);
        repeat (3) tick();

        // Reset mid-count on ch0 (cnt=5 after edge 6), switch held through it.
        sw_in = 4'b0001;
        repeat (7) tick();
        chk("midcnt_pending", sw_o, 4'b0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midcnt_reset", {sw_o, press_o, rel_o, tog_o}, 32'h0);
        for (int i = 0; i < LAT; i++) begin
            tick();
            chk("midcnt_no_press", press_o, 4'b0000);
        end
        tick();
        chk("midcnt_press", press_o, 4'b0001);
        chk("midcnt_toggle", tog_o, 4'b0001);
        chk("midcnt_sw", sw_o, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
